// File: rtl/reg_abi_name.sv
// RISC-V integer register index to ABI mnemonic lookup, registered with one cycle of latency.
// The name is packed ASCII, right-justified and NUL-padded, so a %0s print shows the bare mnemonic.
module reg_abi_name #(
  parameter int IDX_W  = 6,
  parameter int NAME_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  output logic [NAME_W-1:0] out_name,
  output logic [2:0]        out_len,
  output logic              out_err
);

  logic [31:0]       tbl_name;
  logic [2:0]        tbl_len;
  logic [NAME_W-1:0] name_nxt;
  logic [2:0]        len_nxt;
  logic              err_nxt;

  logic              vld_p0;
  logic [NAME_W-1:0] name_p0;
  logic [2:0]        len_p0;
  logic              err_p0;

  always_comb begin
    tbl_name = 32'h0;
    tbl_len  = 3'd2;
    case (in_idx[4:0])
      5'd0:  begin tbl_name = 32'h7A65726F; tbl_len = 3'd4; end
      5'd1:  tbl_name = 32'h00007261;
      5'd2:  tbl_name = 32'h00007370;
      5'd3:  tbl_name = 32'h00006770;
      5'd4:  tbl_name = 32'h00007470;
      5'd5:  tbl_name = 32'h00007430;
      5'd6:  tbl_name = 32'h00007431;
      5'd7:  tbl_name = 32'h00007432;
      5'd8:  tbl_name = 32'h00007330;
      5'd9:  tbl_name = 32'h00007331;
      5'd10: tbl_name = 32'h00006130;
      5'd11: tbl_name = 32'h00006131;
      5'd12: tbl_name = 32'h00006132;
      5'd13: tbl_name = 32'h00006133;
      5'd14: tbl_name = 32'h00006134;
      5'd15: tbl_name = 32'h00006135;
      5'd16: tbl_name = 32'h00006136;
      5'd17: tbl_name = 32'h00006137;
      5'd18: tbl_name = 32'h00007332;
      5'd19: tbl_name = 32'h00007333;
      5'd20: tbl_name = 32'h00007334;
      5'd21: tbl_name = 32'h00007335;
      5'd22: tbl_name = 32'h00007336;
      5'd23: tbl_name = 32'h00007337;
      5'd24: tbl_name = 32'h00007338;
      5'd25: tbl_name = 32'h00007339;
      5'd26: begin tbl_name = 32'h00733130; tbl_len = 3'd3; end
      5'd27: begin tbl_name = 32'h00733131; tbl_len = 3'd3; end
      5'd28: tbl_name = 32'h00007433;
      5'd29: tbl_name = 32'h00007434;
      5'd30: tbl_name = 32'h00007435;
      5'd31: tbl_name = 32'h00007436;
      default: begin
        tbl_name = 32'h0;
        tbl_len  = 3'd0;
      end
    endcase
  end

  // Any set bit above the low five means the index is past x31.
  always_comb begin
    name_nxt = '0;
    len_nxt  = 3'd0;
    err_nxt  = 1'b0;
    if (|in_idx[IDX_W-1:5]) begin
      err_nxt = 1'b1;
    end else begin
      name_nxt[31:0] = tbl_name;
      len_nxt        = tbl_len;
    end
  end

  // Stage p0: registered lookup result; data holds when no request arrives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p0  <= 1'b0;
      name_p0 <= '0;
      len_p0  <= 3'd0;
      err_p0  <= 1'b0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        name_p0 <= name_nxt;
        len_p0  <= len_nxt;
        err_p0  <= err_nxt;
      end
    end
  end

  assign out_valid = vld_p0;
  assign out_name  = name_p0;
  assign out_len   = len_p0;
  assign out_err   = err_p0;

endmodule

// File: tb/tb_reg_abi_name.sv
// Bench for reg_abi_name: directed sequence then random traffic against a string-based name model.
module tb_reg_abi_name;

  localparam int IDX_W  = 6;
  localparam int NAME_W = 33;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [IDX_W-1:0]  in_idx;
  logic              out_valid;
  logic [NAME_W-1:0] out_name;
  logic [2:0]        out_len;
  logic              out_err;

  int checks;
  int errors;

  string abi [32];

  logic              exp_vld;
  logic [NAME_W-1:0] exp_name;
  logic [2:0]        exp_len;
  logic              exp_err;

  reg_abi_name #(.IDX_W(IDX_W), .NAME_W(NAME_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_name  (out_name),
    .out_len   (out_len),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NAME_W-1:0] pack_name(input string s);
    logic [NAME_W-1:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v = (v << 8) | NAME_W'(s[i]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input logic r, input logic v, input int idx);
    reset    = r;
    in_valid = v;
    in_idx   = IDX_W'(idx);
    @(posedge clk);
    #1;
    if (!r) begin
      exp_vld = 1'b0; exp_name = '0; exp_len = 3'd0; exp_err = 1'b0;
    end else if (v) begin
      exp_vld = 1'b1;
      if (idx >= 32) begin
        exp_err = 1'b1; exp_name = '0; exp_len = 3'd0;
      end else begin
        exp_err  = 1'b0;
        exp_name = pack_name(abi[idx]);
        exp_len  = 3'(abi[idx].len());
      end
    end else begin
      exp_vld = 1'b0;
    end
    chk($sformatf("valid idx%0d", idx), 64'(out_valid), 64'(exp_vld));
    chk($sformatf("name idx%0d", idx),  64'(out_name),  64'(exp_name));
    chk($sformatf("len idx%0d", idx),   64'(out_len),   64'(exp_len));
    chk($sformatf("err idx%0d", idx),   64'(out_err),   64'(exp_err));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    abi[0] = "zero"; abi[1] = "ra"; abi[2] = "sp"; abi[3] = "gp"; abi[4] = "tp";
    for (int i = 0; i < 3; i++)  abi[5 + i]  = $sformatf("t%0d", i);
    abi[8] = "s0"; abi[9] = "s1";
    for (int i = 0; i < 8; i++)  abi[10 + i] = $sformatf("a%0d", i);
    for (int i = 2; i < 12; i++) abi[16 + i] = $sformatf("s%0d", i);
    for (int i = 3; i < 7; i++)  abi[25 + i] = $sformatf("t%0d", i);

    // Reset held with a live request: it must be dropped.
    step(1'b0, 1'b1, 5);
    step(1'b0, 1'b1, 5);

    step(1'b1, 1'b1, 0);
    chk("zero literal", 64'(out_name), 64'(33'h07A65726F));
    chk("zero len literal", 64'(out_len), 64'd4);

    step(1'b1, 1'b1, 2);
    chk("sp literal", 64'(out_name), 64'(33'h000007370));
    step(1'b1, 1'b1, 8);
    chk("s0 literal", 64'(out_name), 64'(33'h000007330));
    step(1'b1, 1'b1, 27);
    chk("s11 literal", 64'(out_name), 64'(33'h000733131));
    chk("s11 len literal", 64'(out_len), 64'd3);

    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b1, i);
      if (i == 10) chk("a0 literal", 64'(out_name), 64'(33'h6130));
      if (i == 31) chk("t6 literal", 64'(out_name), 64'(33'h7436));
    end

    step(1'b1, 1'b1, 40);
    chk("oor err literal", 64'(out_err), 64'd1);
    step(1'b1, 1'b1, 1);
    chk("ra literal", 64'(out_name), 64'(33'h7261));

    step(1'b1, 1'b1, 4);
    step(1'b1, 1'b0, 9);
    chk("tp hold literal", 64'(out_name), 64'(33'h7470));
    step(1'b0, 1'b0, 9);
    chk("reset clear literal", 64'(out_name), 64'd0);

    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(15, 0) != 0), ($urandom_range(3, 0) != 0), int'($urandom_range(63, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
